// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline types, FSM state encoding and register-number width
package hazard_ctrl_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MWAIT = 2'd2} state_e;
endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds an operand of the ID instruction
// Ports: id_rs_i/id_rt_i ID source regs, ex_rt_i EX load dest, ex_mem_read_i EX is load, load_use_o hazard
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             ex_mem_read_i,
  output logic             load_use_o
);
  assign load_use_o = ex_mem_read_i && (ex_rt_i != '0) && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit (memory freeze > branch flush > load-use stall)
// Ports: clk, rst (async active-low); IDRs/IDRt/EXRt/EXMemRead load-use inputs; BranchTaken; MemBusy;
// PCWrite/IFIDWrite/IFIDFlush/IDEXBubble/IDEXHold pipeline controls;
// StallCnt saturating stall counter, present only when HAZARD_STALL_CNT_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IDRs,
  input  logic [REG_W-1:0] IDRt,
  input  logic [REG_W-1:0] EXRt,
  input  logic             EXMemRead,
  input  logic             BranchTaken,
  input  logic             MemBusy,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             IDEXHold
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt
`endif
);
  localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
  state_e     state_q, state_d, eff;
  logic [2:0] fcnt_q, fcnt_d;
  logic       lu, pcw, ifw, fl, bub, hold;
  load_use_detect u_lud (
    .id_rs_i      (IDRs),
    .id_rt_i      (IDRt),
    .ex_rt_i      (EXRt),
    .ex_mem_read_i(EXMemRead),
    .load_use_o   (lu)
  );
  // Leaving MWAIT behaves as the state it resumes into within the same cycle.
  always_comb begin
    eff     = (state_q == MWAIT) ? ((fcnt_q == 3'd0) ? RUN : FLUSH) : state_q;
    state_d = RUN;
    fcnt_d  = fcnt_q;
    pcw     = 1'b1;
    ifw     = 1'b1;
    fl      = 1'b0;
    bub     = 1'b0;
    hold    = 1'b0;
    if (MemBusy) begin
      pcw     = 1'b0;
      ifw     = 1'b0;
      hold    = 1'b1;
      state_d = MWAIT;
    end else if (BranchTaken) begin
      fl      = 1'b1;
      fcnt_d  = FL_INIT;
      state_d = (FL_INIT != 3'd0) ? FLUSH : RUN;
    end else if (eff == FLUSH) begin
      fl      = 1'b1;
      fcnt_d  = fcnt_q - 3'd1;
      state_d = (fcnt_d == 3'd0) ? RUN : FLUSH;
    end else if (lu) begin
      pcw = 1'b0;
      ifw = 1'b0;
      bub = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end
  // Reset forces a safe frozen pipeline with NOPs in IF/ID and ID/EX.
  assign PCWrite    = rst & pcw;
  assign IFIDWrite  = rst & ifw;
  assign IFIDFlush  = ~rst | fl;
  assign IDEXBubble = ~rst | bub;
  assign IDEXHold   = rst & hold;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  assign stall_d = ((!pcw || fl) && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign StallCnt = stall_q;
`endif
endmodule
